// File: rtl/priority_arbiter_rr_if.sv
// Request/grant bundle shared by the arbiter and its requester side.
// The master side drives requests and acknowledges; the slave side (the
// arbiter) returns the registered grant.
interface priority_arbiter_rr_if #(
   parameter int N = 8,
   parameter int W = $clog2(N)
);
   logic [N-1:0] req;
   logic         mode;
   logic         ack;
   logic         valid;
   logic [W-1:0] grant_idx;
   logic [N-1:0] grant_onehot;

   modport master (
      output req,
      output mode,
      output ack,
      input  valid,
      input  grant_idx,
      input  grant_onehot
   );

   modport slave (
      input  req,
      input  mode,
      input  ack,
      output valid,
      output grant_idx,
      output grant_onehot
   );
endinterface

// File: rtl/priority_arbiter_rr.sv
// N-way arbiter with selectable fixed-priority (highest index wins) or
// round-robin policy. A grant is held until acknowledged; an acknowledge
// with pending requests re-arbitrates in the same edge so grants can
// stream back-to-back. The round-robin pointer always advances past an
// acknowledged grant, so the search on that same edge already starts
// from the requester following the one just served.
module priority_arbiter_rr #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   priority_arbiter_rr_if.slave bus
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   state_e       state_q;
   logic [W-1:0] grant_idx_q;
   logic [N-1:0] grant_onehot_q;
   logic [W-1:0] ptr_q;
   logic [W-1:0] ptr_d;

   logic         arb_en;
   logic         any_req;
   logic [W-1:0] win_idx;

   // Arbitration happens from IDLE, or from GRANT when the holder acknowledges.
   assign arb_en  = (state_q == IDLE) || bus.ack;
   assign any_req = |bus.req;

   // Pointer moves to the slot after an acknowledged grant; otherwise it holds.
   always_comb begin
      ptr_d = ptr_q;
      if ((state_q == GRANT) && bus.ack) begin
         if (grant_idx_q == W'(N - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = grant_idx_q + 1'b1;
         end
      end
   end

   // Winner selection: highest set index (fixed) or first set bit at/after ptr (round-robin).
   always_comb begin
      int j;
      j       = 0;
      win_idx = '0;
      if (!bus.mode) begin
         for (int i = 0; i < N; i++) begin
            if (bus.req[i]) begin
               win_idx = W'(i);
            end
         end
      end else begin
         // Descending scan so the smallest offset from ptr is written last and wins.
         for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr_d) + k) % N;
            if (bus.req[j]) begin
               win_idx = W'(j);
            end
         end
      end
   end

   // Grant FSM with registered outputs and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         grant_idx_q    <= '0;
         grant_onehot_q <= '0;
         ptr_q          <= '0;
      end else begin
         ptr_q <= ptr_d;
         if (arb_en) begin
            if (any_req) begin
               state_q        <= GRANT;
               grant_idx_q    <= win_idx;
               grant_onehot_q <= {{(N - 1){1'b0}}, 1'b1} << win_idx;
            end else begin
               state_q        <= IDLE;
               grant_idx_q    <= '0;
               grant_onehot_q <= '0;
            end
         end
      end
   end

   assign bus.valid        = (state_q == GRANT);
   assign bus.grant_idx    = grant_idx_q;
   assign bus.grant_onehot = grant_onehot_q;

endmodule

// File: tb/tb_priority_arbiter_rr.sv
// Directed bench for priority_arbiter_rr with N = 8: a table of per-edge
// vectors plus hand-written sequences for reset, sweep and hold corners.
module tb_priority_arbiter_rr;

   localparam int N = 8;

   logic clk;
   logic rst_n;

   int checks;
   int failures;

   priority_arbiter_rr_if #(.N(N)) bus ();

   priority_arbiter_rr #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] req;
      logic       mode;
      logic       ack;
      logic       ev;
      logic [2:0] ei;
      logic [7:0] eo;
   } vec_t;

   vec_t vecs[14];

   task automatic check_out(input string name, input logic ev, input logic [2:0] ei,
                            input logic [7:0] eo);
      checks++;
      if (bus.valid !== ev) begin
         failures++;
         $display("FAIL %s valid got=%0b exp=%0b", name, bus.valid, ev);
      end
      checks++;
      if (bus.grant_idx !== ei) begin
         failures++;
         $display("FAIL %s grant_idx got=%0d exp=%0d", name, bus.grant_idx, ei);
      end
      checks++;
      if (bus.grant_onehot !== eo) begin
         failures++;
         $display("FAIL %s grant_onehot got=%h exp=%h", name, bus.grant_onehot, eo);
      end
   endtask

   task automatic step(input logic [7:0] r, input logic m, input logic a);
      bus.req  = r;
      bus.mode = m;
      bus.ack  = a;
      @(posedge clk);
      #1;
   endtask

   // Assert reset mid-cycle, verify outputs cleared immediately, release on a falling edge.
   task automatic do_reset(input string name);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_out(name, 1'b0, 3'd0, 8'h00);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b1;
      bus.req  = 8'hFF;
      bus.mode = 1'b1;
      bus.ack  = 1'b0;

      //            req    mode  ack   ev    ei     eo
      vecs[0]  = '{8'h25, 1'b0, 1'b0, 1'b1, 3'd5, 8'h20};
      vecs[1]  = '{8'h25, 1'b0, 1'b0, 1'b1, 3'd5, 8'h20};
      vecs[2]  = '{8'h00, 1'b1, 1'b0, 1'b1, 3'd5, 8'h20};
      vecs[3]  = '{8'h25, 1'b0, 1'b1, 1'b1, 3'd5, 8'h20};
      vecs[4]  = '{8'h09, 1'b1, 1'b1, 1'b1, 3'd0, 8'h01};
      vecs[5]  = '{8'h09, 1'b1, 1'b1, 1'b1, 3'd3, 8'h08};
      vecs[6]  = '{8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00};
      vecs[7]  = '{8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00};
      vecs[8]  = '{8'hFF, 1'b1, 1'b0, 1'b1, 3'd4, 8'h10};
      vecs[9]  = '{8'hFF, 1'b1, 1'b1, 1'b1, 3'd5, 8'h20};
      vecs[10] = '{8'h80, 1'b0, 1'b1, 1'b1, 3'd7, 8'h80};
      vecs[11] = '{8'h81, 1'b1, 1'b1, 1'b1, 3'd0, 8'h01};
      vecs[12] = '{8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00};
      vecs[13] = '{8'h03, 1'b1, 1'b0, 1'b1, 3'd1, 8'h02};

      // Reset with all requests pending; first round-robin grant is index 0.
      #3;
      do_reset("reset_req_ff");
      step(8'hFF, 1'b1, 1'b0);
      check_out("reset_first_rr", 1'b1, 3'd0, 8'h01);

      // Table-driven vectors from a fresh reset (ptr = 0).
      do_reset("reset_table");
      for (int i = 0; i < 14; i++) begin
         step(vecs[i].req, vecs[i].mode, vecs[i].ack);
         check_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ei, vecs[i].eo);
      end

      // Round-robin sweep with continuous acknowledge: 0..7,0,1.
      do_reset("reset_sweep");
      for (int i = 0; i < 10; i++) begin
         logic [2:0] e;
         e = 3'(i % N);
         step(8'hFF, 1'b1, 1'b1);
         check_out($sformatf("sweep%0d", i), 1'b1, e, 8'h01 << e);
      end

      // Hold while unacknowledged with requests withdrawn, then release to IDLE.
      do_reset("reset_hold");
      step(8'h08, 1'b0, 1'b0);
      check_out("hold_grant", 1'b1, 3'd3, 8'h08);
      for (int i = 0; i < 4; i++) begin
         step(8'h00, 1'b0, 1'b0);
         check_out($sformatf("hold%0d", i), 1'b1, 3'd3, 8'h08);
      end
      step(8'h00, 1'b0, 1'b1);
      check_out("release", 1'b0, 3'd0, 8'h00);

      // Asynchronous reset mid-grant discards the grant and clears the pointer.
      step(8'h10, 1'b0, 1'b0);
      check_out("pre_async", 1'b1, 3'd4, 8'h10);
      step(8'h10, 1'b0, 1'b1);
      check_out("pre_async_ack", 1'b1, 3'd4, 8'h10);
      do_reset("async_mid_grant");
      step(8'hFF, 1'b1, 1'b0);
      check_out("post_async_rr", 1'b1, 3'd0, 8'h01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
